// File: rtl/arp_ctrl_pkg.sv
// Shared types and constants for the ARP lookup controller.
//   - state_t     : controller FSM states (IDLE, CPU, SEARCH, RESULT)
//   - arp_entry_t : one ARP table entry {vld, ip, mac}
//   - IP_W/MAC_W/OQ_W : field widths
package arp_ctrl_pkg;

    localparam int IP_W  = 32;
    localparam int MAC_W = 48;
    localparam int OQ_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CPU    = 2'd1,
        S_SEARCH = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    typedef struct packed {
        logic             vld;
        logic [IP_W-1:0]  ip;
        logic [MAC_W-1:0] mac;
    } arp_entry_t;

endpackage

// File: rtl/arp_table_regs.sv
// ARP table register file.
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   lkp_idx_i                : index for the search compare port
//   lkp_vld_o/ip_o/mac_o     : entry at lkp_idx_i (combinational)
//   wr_en_i                  : write entry cpu_addr_i this cycle
//   cpu_addr_i               : CPU read/write index
//   wr_vld_i/ip_i/mac_i      : write data
//   cpu_vld_o/ip_o/mac_o     : entry at cpu_addr_i (combinational)
// Only the valid bits are reset; ip/mac contents are don't-care while invalid.
module arp_table_regs
    import arp_ctrl_pkg::*;
#(
    parameter int ARP_DEPTH = 32,
    parameter int ADDR_BITS = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [ADDR_BITS-1:0] lkp_idx_i,
    output logic                 lkp_vld_o,
    output logic [IP_W-1:0]      lkp_ip_o,
    output logic [MAC_W-1:0]     lkp_mac_o,
    input  logic                 wr_en_i,
    input  logic [ADDR_BITS-1:0] cpu_addr_i,
    input  logic                 wr_vld_i,
    input  logic [IP_W-1:0]      wr_ip_i,
    input  logic [MAC_W-1:0]     wr_mac_i,
    output logic                 cpu_vld_o,
    output logic [IP_W-1:0]      cpu_ip_o,
    output logic [MAC_W-1:0]     cpu_mac_o
);

    logic [ARP_DEPTH-1:0] vld_q;
    logic [IP_W-1:0]      ip_q  [ARP_DEPTH];
    logic [MAC_W-1:0]     mac_q [ARP_DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
        end else if (wr_en_i) begin
            vld_q[cpu_addr_i] <= wr_vld_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            ip_q[cpu_addr_i]  <= wr_ip_i;
            mac_q[cpu_addr_i] <= wr_mac_i;
        end
    end

    assign lkp_vld_o = vld_q[lkp_idx_i];
    assign lkp_ip_o  = ip_q[lkp_idx_i];
    assign lkp_mac_o = mac_q[lkp_idx_i];
    assign cpu_vld_o = vld_q[cpu_addr_i];
    assign cpu_ip_o  = ip_q[cpu_addr_i];
    assign cpu_mac_o = mac_q[cpu_addr_i];

endmodule

// File: rtl/arp_lookup_ctrl.sv
// ARP lookup controller: owns the ARP table, searches it sequentially for
// next-hop lookups and arbitrates those against CPU table reads/writes.
// Ports:
//   AXI_ACLK, AXI_RESETN          : clock, asynchronous active-low reset
//   lkp_req_valid/ready, lkp_next_hop, lkp_oq : lookup request
//   res_valid/ready, res_hit, res_mac, res_oq : lookup result
//   cpu_req/we/addr/wr_*, cpu_ack, cpu_rd_*   : CPU table access
//   counter_reset, lookup_count, hit_count    : statistics
//   dbg_state                     : current FSM state (state_t encoding)
// Handshakes: a lookup transfers on the rising edge where lkp_req_valid and
// lkp_req_ready are both high; a result transfers where res_valid and
// res_ready are both high. res_* are held stable while res_valid is high.
// cpu_req is a level held until the single-cycle cpu_ack pulse.
// Optional: define ARP_LAST_HIT_CACHE_EN for a one-entry last-hit cache.
module arp_lookup_ctrl
    import arp_ctrl_pkg::*;
#(
    parameter int ARP_DEPTH          = 32,
    parameter int ADDR_BITS          = 5,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                          AXI_ACLK,
    input  logic                          AXI_RESETN,
    input  logic                          lkp_req_valid,
    output logic                          lkp_req_ready,
    input  logic [31:0]                   lkp_next_hop,
    input  logic [7:0]                    lkp_oq,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic                          res_hit,
    output logic [47:0]                   res_mac,
    output logic [7:0]                    res_oq,
    input  logic                          cpu_req,
    input  logic                          cpu_we,
    input  logic [ADDR_BITS-1:0]          cpu_addr,
    input  logic [31:0]                   cpu_wr_ip,
    input  logic [47:0]                   cpu_wr_mac,
    input  logic                          cpu_wr_vld,
    output logic                          cpu_ack,
    output logic [31:0]                   cpu_rd_ip,
    output logic [47:0]                   cpu_rd_mac,
    output logic                          cpu_rd_vld,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] counter_reset,
    output logic [C_S_AXI_DATA_WIDTH-1:0] lookup_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0] hit_count,
    output logic [1:0]                    dbg_state
);

    state_t               state_q;
    logic                 last_lkp_q;   // last grant went to a lookup
    logic [IP_W-1:0]      nh_q;
    logic [ADDR_BITS-1:0] idx_q;
    // One-stage compare pipeline: result of entry idx is acted on a cycle later.
    logic                 pipe_vld_q;
    logic                 pipe_hit_q;
    logic                 pipe_last_q;
    logic [MAC_W-1:0]     pipe_mac_q;

    arp_entry_t lkp_entry;
    arp_entry_t cpu_entry;
    logic       tbl_we;
    logic       ent_match;
    logic       cpu_pend;
    logic       cpu_win;
    logic       lkp_win;
    logic       cache_hit;
    logic [MAC_W-1:0] cache_mac;

    arp_table_regs #(
        .ARP_DEPTH (ARP_DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_table (
        .clk_i      (AXI_ACLK),
        .rst_ni     (AXI_RESETN),
        .lkp_idx_i  (idx_q),
        .lkp_vld_o  (lkp_entry.vld),
        .lkp_ip_o   (lkp_entry.ip),
        .lkp_mac_o  (lkp_entry.mac),
        .wr_en_i    (tbl_we),
        .cpu_addr_i (cpu_addr),
        .wr_vld_i   (cpu_wr_vld),
        .wr_ip_i    (cpu_wr_ip),
        .wr_mac_i   (cpu_wr_mac),
        .cpu_vld_o  (cpu_entry.vld),
        .cpu_ip_o   (cpu_entry.ip),
        .cpu_mac_o  (cpu_entry.mac)
    );

    assign tbl_we    = (state_q == S_CPU) && cpu_we;
    assign ent_match = lkp_entry.vld && (lkp_entry.ip == nh_q);

    // cpu_req is still high during the ack cycle; do not re-grant it then.
    assign cpu_pend = cpu_req && !cpu_ack;
    // Alternating priority: CPU wins a tie only if the previous grant was a lookup.
    assign cpu_win  = (state_q == S_IDLE) && cpu_pend && (!lkp_req_valid || last_lkp_q);
    assign lkp_win  = (state_q == S_IDLE) && lkp_req_valid && !cpu_win;
    assign lkp_req_ready = AXI_RESETN && lkp_win;
    assign dbg_state = state_q;

`ifdef ARP_LAST_HIT_CACHE_EN
    logic             cache_vld_q;
    logic [IP_W-1:0]  cache_ip_q;
    logic [MAC_W-1:0] cache_mac_q;
    logic             search_hit;

    assign search_hit = (state_q == S_SEARCH) && pipe_vld_q && pipe_hit_q;
    assign cache_hit  = cache_vld_q && (cache_ip_q == lkp_next_hop);
    assign cache_mac  = cache_mac_q;

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            cache_vld_q <= 1'b0;
            cache_ip_q  <= '0;
            cache_mac_q <= '0;
        end else if (tbl_we) begin
            cache_vld_q <= 1'b0;
        end else if (search_hit) begin
            cache_vld_q <= 1'b1;
            cache_ip_q  <= nh_q;
            cache_mac_q <= pipe_mac_q;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_mac = '0;
`endif

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            state_q     <= S_IDLE;
            last_lkp_q  <= 1'b1;   // CPU gets the first contested grant
            nh_q        <= '0;
            idx_q       <= '0;
            pipe_vld_q  <= 1'b0;
            pipe_hit_q  <= 1'b0;
            pipe_last_q <= 1'b0;
            pipe_mac_q  <= '0;
            res_valid   <= 1'b0;
            res_hit     <= 1'b0;
            res_mac     <= '0;
            res_oq      <= '0;
            cpu_ack     <= 1'b0;
            cpu_rd_ip   <= '0;
            cpu_rd_mac  <= '0;
            cpu_rd_vld  <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cpu_win) begin
                        state_q    <= S_CPU;
                        last_lkp_q <= 1'b0;
                    end else if (lkp_win) begin
                        last_lkp_q <= 1'b1;
                        nh_q       <= lkp_next_hop;
                        res_oq     <= lkp_oq;
                        idx_q      <= '0;
                        pipe_vld_q <= 1'b0;
                        if (cache_hit) begin
                            state_q   <= S_RESULT;
                            res_valid <= 1'b1;
                            res_hit   <= 1'b1;
                            res_mac   <= cache_mac;
                        end else begin
                            state_q <= S_SEARCH;
                        end
                    end
                end
                S_CPU: begin
                    cpu_ack <= 1'b1;
                    if (!cpu_we) begin
                        cpu_rd_vld <= cpu_entry.vld;
                        cpu_rd_ip  <= cpu_entry.ip;
                        cpu_rd_mac <= cpu_entry.mac;
                    end
                    state_q <= S_IDLE;
                end
                S_SEARCH: begin
                    // Earlier indices resolve first, so the lowest matching index wins.
                    if (pipe_vld_q && (pipe_hit_q || pipe_last_q)) begin
                        state_q    <= S_RESULT;
                        res_valid  <= 1'b1;
                        res_hit    <= pipe_hit_q;
                        res_mac    <= pipe_hit_q ? pipe_mac_q : '0;
                        pipe_vld_q <= 1'b0;
                    end else begin
                        pipe_vld_q  <= 1'b1;
                        pipe_hit_q  <= ent_match;
                        pipe_mac_q  <= lkp_entry.mac;
                        pipe_last_q <= (idx_q == ADDR_BITS'(ARP_DEPTH - 1));
                        idx_q       <= idx_q + 1'b1;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Counters; a clear request takes precedence over a same-cycle increment.
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            lookup_count <= '0;
            hit_count    <= '0;
        end else if (counter_reset == C_S_AXI_DATA_WIDTH'(1)) begin
            lookup_count <= '0;
            hit_count    <= '0;
        end else if ((state_q == S_RESULT) && res_ready) begin
            lookup_count <= lookup_count + 1'b1;
            if (res_hit) begin
                hit_count <= hit_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/arp_lookup_ctrl.md
Name: arp_lookup_ctrl

Overview:
- Owns the ARP table and schedules every access to it.
- Accepts per-packet next-hop lookups from the LPM stage, searches the table sequentially, and returns {hit, dest MAC, output queue} to the header-rewrite stage on a valid/ready handshake.
- Arbitrates those lookups against CPU register-interface reads and writes of table entries. Keeps lookup and hit counters.

Parameters:
- ARP_DEPTH, 32, number of table entries (power of two, >=2).
- ADDR_BITS, 5, log2(ARP_DEPTH).
- C_S_AXI_DATA_WIDTH, 32, counter/clear register width.

Ports:
- AXI_ACLK  in  1  single clock.
- AXI_RESETN  in  1  reset, asynchronous, active-low.
- lkp_req_valid  in  1  lookup request valid.
- lkp_req_ready  out  1  lookup accepted when valid&ready.
- lkp_next_hop  in  32  next-hop IPv4 address.
- lkp_oq  in  8  one-hot output queue from LPM.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts result.
- res_hit  out  1  entry found.
- res_mac  out  48  destination MAC (0 on miss).
- res_oq  out  8  lkp_oq carried through.
- cpu_req  in  1  CPU table access, held high until cpu_ack.
- cpu_we  in  1  1=write, 0=read; sampled with cpu_req.
- cpu_addr  in  ADDR_BITS  entry index.
- cpu_wr_ip  in  32  entry IP.
- cpu_wr_mac  in  48  entry MAC.
- cpu_wr_vld  in  1  entry valid bit.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rd_ip  out  32  read data.
- cpu_rd_mac  out  48  read data.
- cpu_rd_vld  out  1  read data.
- counter_reset  in  32  value 1 clears counters.
- lookup_count  out  32  completed lookups.
- hit_count  out  32  completed hits.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - All table valid bits, outputs and counters = 0.
  - lkp_req_ready = 0 while in reset.
- FSM states: IDLE, CPU, SEARCH, RESULT.
- IDLE:
  - If cpu_req and (no lkp_req_valid or last grant was a lookup): go to CPU.
  - Else if lkp_req_valid: lkp_req_ready=1 this cycle; latch next_hop/oq; index=0; go to SEARCH.
  - lkp_req_ready is combinational: high only in IDLE when the lookup wins arbitration.
- Arbitration: alternating priority when both requesters are pending; neither side can be starved. A search in progress is never preempted.
- CPU state (1 cycle):
  - Write: updates entry cpu_addr.
  - Read: registers the entry onto cpu_rd_*.
  - cpu_ack=1 on the following cycle; return to IDLE. cpu_rd_* hold until the next read.
- SEARCH:
  - Compares one entry per cycle: valid && ip==next_hop.
  - Match at index k: res_hit=1, res_mac=entry mac, go to RESULT. res_valid rises k+2 cycles after the accept edge.
  - No match at index ARP_DEPTH-1: res_hit=0, res_mac=0; res_valid rises ARP_DEPTH+1 cycles after accept.
  - Duplicate IPs: the lowest index wins.
- RESULT:
  - res_* held stable while res_valid=1 && !res_ready.
  - On handshake: go to IDLE. lookup_count+1; hit_count+1 if res_hit.
- Counters wrap at 2^32-1 → 0. counter_reset==1 clears both; clear wins over a same-cycle increment.
- lkp_next_hop=0 is looked up like any other address; no special case.

Optional Feature:
- ARP_LAST_HIT_CACHE_EN defined:
  - A one-entry register {vld, ip, mac} holds the most recent hit.
  - A lookup whose next_hop equals the cached ip (cache vld) goes from IDLE straight to RESULT: res_valid one cycle after accept, res_hit=1; it still counts as a lookup and a hit.
  - Any CPU write clears cache vld in the same cycle.
- Macro undefined: the cache is absent; all lookups use SEARCH.

Decomposition:
- Package arp_ctrl_pkg: state enum (IDLE/CPU/SEARCH/RESULT), arp_entry_t struct {vld, ip[31:0], mac[47:0]}, IP/MAC/OQ width constants.
- Sub-module arp_table_regs: ARP_DEPTH entry register file with one indexed compare/read port and one CPU read/write port; valid bits cleared on reset.

Test Plan:
- Write entry 3={10.0.0.2, 00:11:22:33:44:55, vld}; lookup 10.0.0.2 oq=0x04 → res_valid 5 cycles after accept, hit=1, mac=0x001122334455, oq=0x04; lookup_count=1, hit_count=1.
- Lookup 10.0.0.9 on the same table → res_valid 33 cycles after accept, hit=0, mac=0; lookup_count=2, hit_count=1.
- cpu_req write and lkp_req_valid asserted in the same cycle, three times back-to-back → grants alternate CPU, lookup, CPU; no lookup waits more than one CPU op.
- Hold res_ready=0 for 10 cycles → res_* stable, lkp_req_ready=0 throughout; a CPU request is not acked until after the handshake.
- Entries 1 and 7 both hold 10.0.0.5 with different MACs → result returns entry 1's MAC; write entry 1 vld=0 → next lookup returns entry 7's MAC.
- Assert AXI_RESETN low mid-SEARCH → state IDLE, res_valid=0 and counters 0 immediately; a lookup after release of a previously written IP misses.
